// File: rtl/id_stage_pkg.sv
// Shared CPU encodings: opcodes, funct codes, ALU operations and the decode bundle
// passed from id_decode to the ID/EX register.
package cpu_defs;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    OP1_RS   = 2'd0,
    OP1_RT   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic {
    OP2_RT  = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_e;

  typedef struct packed {
    alu_op_e     aluop;
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        re1;
    logic        re2;
    logic [4:0]  waddr;
    logic        we;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return 32'(s);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of IF/ID, regfile, forwarding and ID/EX signals around the decode stage.
interface id_stage_if;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_stall;
  logic        ex_stall;
  logic        flush;
  logic        re1;
  logic        re2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        fw_ex_we;
  logic        fw_ex_load;
  logic [4:0]  fw_ex_waddr;
  logic [31:0] fw_ex_wdata;
  logic        fw_mem_we;
  logic [4:0]  fw_mem_waddr;
  logic [31:0] fw_mem_wdata;
  logic        ex_valid;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_opnd1;
  logic [31:0] ex_opnd2;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;

  modport slave (
    input  if_valid, if_inst, if_pc, ex_stall, flush, rdata1, rdata2,
           fw_ex_we, fw_ex_load, fw_ex_waddr, fw_ex_wdata,
           fw_mem_we, fw_mem_waddr, fw_mem_wdata,
    output id_stall, re1, re2, raddr1, raddr2,
           ex_valid, ex_aluop, ex_opnd1, ex_opnd2, ex_we, ex_waddr,
           ex_mem_rd, ex_mem_wr, ex_store_data, ex_pc
  );

  modport master (
    output if_valid, if_inst, if_pc, ex_stall, flush, rdata1, rdata2,
           fw_ex_we, fw_ex_load, fw_ex_waddr, fw_ex_wdata,
           fw_mem_we, fw_mem_waddr, fw_mem_wdata,
    input  id_stall, re1, re2, raddr1, raddr2,
           ex_valid, ex_aluop, ex_opnd1, ex_opnd2, ex_we, ex_waddr,
           ex_mem_rd, ex_mem_wr, ex_store_data, ex_pc
  );
endinterface

// File: rtl/id_stage_decode.sv
// Combinational MIPS-subset decoder: operation, operand selection, immediate,
// read enables, destination, memory flags and an illegal-encoding flag.
module id_decode
  import cpu_defs::*;
(
  input  logic [31:0] i_inst,
  output dec_t        o_dec
);

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;

  assign w_op    = i_inst[31:26];
  assign w_funct = i_inst[5:0];
  assign w_rd    = i_inst[15:11];
  assign w_shamt = i_inst[10:6];
  assign w_imm   = i_inst[15:0];

  always_comb begin
    o_dec         = '0;
    o_dec.aluop   = ALU_ADD;
    o_dec.op1_sel = OP1_RS;
    o_dec.op2_sel = OP2_IMM;
    o_dec.rs      = i_inst[25:21];
    o_dec.rt      = i_inst[20:16];
    case (w_op)
      OP_SPECIAL: begin
        o_dec.re1     = 1'b1;
        o_dec.re2     = 1'b1;
        o_dec.op2_sel = OP2_RT;
        o_dec.waddr   = w_rd;
        o_dec.we      = 1'b1;
        case (w_funct)
          FN_ADDU: o_dec.aluop = ALU_ADD;
          FN_SUBU: o_dec.aluop = ALU_SUB;
          FN_AND:  o_dec.aluop = ALU_AND;
          FN_OR:   o_dec.aluop = ALU_OR;
          FN_XOR:  o_dec.aluop = ALU_XOR;
          FN_SLT:  o_dec.aluop = ALU_SLT;
          FN_SLL, FN_SRL: begin
            // Shifts take the value from rt and the amount from shamt; rs is unused.
            o_dec.aluop   = (w_funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            o_dec.re1     = 1'b0;
            o_dec.op1_sel = OP1_RT;
            o_dec.op2_sel = OP2_IMM;
            o_dec.imm     = {27'b0, w_shamt};
          end
          default: begin
            o_dec.re1     = 1'b0;
            o_dec.re2     = 1'b0;
            o_dec.we      = 1'b0;
            o_dec.waddr   = '0;
            o_dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDIU, OP_LW: begin
        o_dec.re1    = 1'b1;
        o_dec.imm    = sext16(w_imm);
        o_dec.waddr  = o_dec.rt;
        o_dec.we     = 1'b1;
        o_dec.mem_rd = (w_op == OP_LW);
      end
      OP_SW: begin
        o_dec.re1    = 1'b1;
        o_dec.re2    = 1'b1;
        o_dec.imm    = sext16(w_imm);
        o_dec.mem_wr = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_dec.re1   = 1'b1;
        o_dec.imm   = {16'b0, w_imm};
        o_dec.waddr = o_dec.rt;
        o_dec.we    = 1'b1;
        o_dec.aluop = (w_op == OP_ANDI) ? ALU_AND :
                      (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        o_dec.op1_sel = OP1_ZERO;
        o_dec.imm     = {w_imm, 16'b0};
        o_dec.aluop   = ALU_OR;
        o_dec.waddr   = o_dec.rt;
        o_dec.we      = 1'b1;
      end
      default: o_dec.illegal = 1'b1;
    endcase
    if (o_dec.waddr == 5'd0) o_dec.we = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: regfile read requests, EX/MEM operand forwarding, load-use stall
// and the ID/EX pipeline register with stall/flush control.
module id_stage
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  dec_t        w_dec;
  logic        w_re1;
  logic        w_re2;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_opnd1;
  logic [31:0] w_opnd2;
  logic        w_load_use;
  logic        w_issue;

  logic        r_vld_p1;
  logic [3:0]  r_aluop_p1;
  logic [31:0] r_opnd1_p1;
  logic [31:0] r_opnd2_p1;
  logic        r_we_p1;
  logic [4:0]  r_waddr_p1;
  logic        r_mem_rd_p1;
  logic        r_mem_wr_p1;
  logic [31:0] r_store_data_p1;
  logic [31:0] r_pc_p1;

  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] rf_data,
    input logic        ex_we,
    input logic [4:0]  ex_addr,
    input logic [31:0] ex_data,
    input logic        mem_we,
    input logic [4:0]  mem_addr,
    input logic [31:0] mem_data
  );
    if (addr == 5'd0)                    return 32'd0;
    else if (ex_we && ex_addr == addr)   return ex_data;
    else if (mem_we && mem_addr == addr) return mem_data;
    else                                 return rf_data;
  endfunction

  id_decode u_decode (
    .i_inst (bus.if_inst),
    .o_dec  (w_dec)
  );

  assign w_re1      = bus.if_valid & w_dec.re1;
  assign w_re2      = bus.if_valid & w_dec.re2;
  assign bus.re1    = w_re1;
  assign bus.re2    = w_re2;
  assign bus.raddr1 = bus.if_valid ? w_dec.rs : 5'd0;
  assign bus.raddr2 = bus.if_valid ? w_dec.rt : 5'd0;

  assign w_rs_val = fwd_sel(w_dec.rs, bus.rdata1, bus.fw_ex_we, bus.fw_ex_waddr, bus.fw_ex_wdata,
                            bus.fw_mem_we, bus.fw_mem_waddr, bus.fw_mem_wdata);
  assign w_rt_val = fwd_sel(w_dec.rt, bus.rdata2, bus.fw_ex_we, bus.fw_ex_waddr, bus.fw_ex_wdata,
                            bus.fw_mem_we, bus.fw_mem_waddr, bus.fw_mem_wdata);

  // A load in EX cannot forward this cycle; only sources actually read can collide.
  assign w_load_use = bus.if_valid && bus.fw_ex_load && bus.fw_ex_we && (bus.fw_ex_waddr != 5'd0) &&
                      ((w_re1 && (w_dec.rs == bus.fw_ex_waddr)) ||
                       (w_re2 && (w_dec.rt == bus.fw_ex_waddr)));
  assign bus.id_stall = w_load_use | bus.ex_stall;
  assign w_issue      = bus.if_valid && !w_load_use && !w_dec.illegal;

  always_comb begin
    w_opnd1 = w_rs_val;
    case (w_dec.op1_sel)
      OP1_RT:   w_opnd1 = w_rt_val;
      OP1_ZERO: w_opnd1 = 32'd0;
      default:  w_opnd1 = w_rs_val;
    endcase
    w_opnd2 = (w_dec.op2_sel == OP2_RT) ? w_rt_val : w_dec.imm;
  end

  // ID/EX boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1        <= 1'b0;
      r_aluop_p1      <= '0;
      r_opnd1_p1      <= '0;
      r_opnd2_p1      <= '0;
      r_we_p1         <= 1'b0;
      r_waddr_p1      <= '0;
      r_mem_rd_p1     <= 1'b0;
      r_mem_wr_p1     <= 1'b0;
      r_store_data_p1 <= '0;
      r_pc_p1         <= '0;
    end else if (bus.flush) begin
      r_vld_p1    <= 1'b0;
      r_we_p1     <= 1'b0;
      r_mem_rd_p1 <= 1'b0;
      r_mem_wr_p1 <= 1'b0;
    end else if (!bus.ex_stall) begin
      r_vld_p1        <= w_issue;
      r_aluop_p1      <= w_issue ? w_dec.aluop  : 4'd0;
      r_opnd1_p1      <= w_issue ? w_opnd1      : 32'd0;
      r_opnd2_p1      <= w_issue ? w_opnd2      : 32'd0;
      r_we_p1         <= w_issue && w_dec.we;
      r_waddr_p1      <= w_issue ? w_dec.waddr  : 5'd0;
      r_mem_rd_p1     <= w_issue && w_dec.mem_rd;
      r_mem_wr_p1     <= w_issue && w_dec.mem_wr;
      r_store_data_p1 <= w_issue ? w_rt_val     : 32'd0;
      r_pc_p1         <= w_issue ? bus.if_pc    : 32'd0;
    end
  end

  assign bus.ex_valid      = r_vld_p1;
  assign bus.ex_aluop      = r_aluop_p1;
  assign bus.ex_opnd1      = r_opnd1_p1;
  assign bus.ex_opnd2      = r_opnd2_p1;
  assign bus.ex_we         = r_we_p1;
  assign bus.ex_waddr      = r_waddr_p1;
  assign bus.ex_mem_rd     = r_mem_rd_p1;
  assign bus.ex_mem_wr     = r_mem_wr_p1;
  assign bus.ex_store_data = r_store_data_p1;
  assign bus.ex_pc         = r_pc_p1;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage with hand-computed expectations.
module tb_id_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_valid     = 1'b0;
    bus.if_inst      = '0;
    bus.if_pc        = '0;
    bus.ex_stall     = 1'b0;
    bus.flush        = 1'b0;
    bus.rdata1       = '0;
    bus.rdata2       = '0;
    bus.fw_ex_we     = 1'b0;
    bus.fw_ex_load   = 1'b0;
    bus.fw_ex_waddr  = '0;
    bus.fw_ex_wdata  = '0;
    bus.fw_mem_we    = 1'b0;
    bus.fw_mem_waddr = '0;
    bus.fw_mem_wdata = '0;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b0;
    bus.if_inst      = $urandom;
    bus.if_pc        = $urandom;
    bus.rdata1       = $urandom;
    bus.rdata2       = $urandom;
    bus.fw_ex_we     = 1'($urandom);
    bus.fw_ex_waddr  = 5'($urandom);
    bus.fw_ex_wdata  = $urandom;
    bus.fw_mem_we    = 1'($urandom);
    bus.fw_mem_wdata = $urandom;
    bus.flush        = 1'($urandom);
    tick();
    tick();
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_ex_we", bus.ex_we, 0);
    chk("rst_ex_opnd1", bus.ex_opnd1, 0);
    chk("rst_ex_opnd2", bus.ex_opnd2, 0);
    chk("rst_ex_pc", bus.ex_pc, 0);
    chk("rst_ex_memwr", bus.ex_mem_wr, 0);
    chk("rst_id_stall", bus.id_stall, 0);
    chk("rst_re1", bus.re1, 0);
    chk("rst_raddr2", bus.raddr2, 0);

    // ADDIU r1, r0, -1
    rst = 1'b1;
    idle();
    issue(itype(6'h09, 5'd0, 5'd1, 16'hFFFF), 32'h100);
    chk("addiu_re1", bus.re1, 1);
    chk("addiu_re2", bus.re2, 0);
    tick();
    chk("addiu_valid", bus.ex_valid, 1);
    chk("addiu_opnd1", bus.ex_opnd1, 0);
    chk("addiu_opnd2", bus.ex_opnd2, 32'hFFFF_FFFF);
    chk("addiu_aluop", bus.ex_aluop, 0);
    chk("addiu_waddr", bus.ex_waddr, 1);
    chk("addiu_we", bus.ex_we, 1);
    chk("addiu_pc", bus.ex_pc, 32'h100);

    // ADDU r3, r19, r19 with EX and MEM both writing r19
    bus.rdata1 = 32'd123456; bus.rdata2 = 32'd123456;
    bus.fw_ex_we = 1'b1;  bus.fw_ex_waddr = 5'd19;  bus.fw_ex_wdata = 32'd654321;
    bus.fw_mem_we = 1'b1; bus.fw_mem_waddr = 5'd19; bus.fw_mem_wdata = 32'd233;
    issue(rtype(5'd19, 5'd19, 5'd3, 5'd0, 6'h21), 32'h104);
    chk("fwd_raddr2", bus.raddr2, 19);
    chk("fwd_re2", bus.re2, 1);
    tick();
    chk("fwd_ex_opnd1", bus.ex_opnd1, 32'd654321);
    chk("fwd_ex_opnd2", bus.ex_opnd2, 32'd654321);
    chk("fwd_ex_waddr", bus.ex_waddr, 3);
    bus.fw_ex_we = 1'b0;
    #1;
    tick();
    chk("fwd_mem_opnd1", bus.ex_opnd1, 32'd233);
    chk("fwd_mem_opnd2", bus.ex_opnd2, 32'd233);

    // OR r4, r0, r0 while EX claims a write to r0
    idle();
    bus.rdata1 = 32'd55; bus.rdata2 = 32'd55;
    bus.fw_ex_we = 1'b1; bus.fw_ex_waddr = 5'd0; bus.fw_ex_wdata = 32'd99;
    issue(rtype(5'd0, 5'd0, 5'd4, 5'd0, 6'h25), 32'h108);
    tick();
    chk("r0_opnd1", bus.ex_opnd1, 0);
    chk("r0_opnd2", bus.ex_opnd2, 0);
    chk("r0_aluop", bus.ex_aluop, 3);
    issue(rtype(5'd1, 5'd1, 5'd0, 5'd0, 6'h21), 32'h10C);
    tick();
    chk("r0_dst_valid", bus.ex_valid, 1);
    chk("r0_dst_we", bus.ex_we, 0);

    // Load-use on rs: ADDU r6, r5, r0 behind a load to r5
    idle();
    bus.fw_ex_load = 1'b1; bus.fw_ex_we = 1'b1; bus.fw_ex_waddr = 5'd5;
    issue(itype(6'h09, 5'd2, 5'd5, 16'd1), 32'h110);
    chk("lu_rt_dest_nostall", bus.id_stall, 0);
    issue(rtype(5'd5, 5'd0, 5'd6, 5'd0, 6'h21), 32'h114);
    chk("lu_stall", bus.id_stall, 1);
    tick();
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_we", bus.ex_we, 0);
    bus.fw_ex_load = 1'b0; bus.fw_ex_we = 1'b0; bus.rdata1 = 32'd77;
    #1;
    chk("lu_clear_stall", bus.id_stall, 0);
    tick();
    chk("lu_issue_valid", bus.ex_valid, 1);
    chk("lu_issue_waddr", bus.ex_waddr, 6);
    chk("lu_issue_opnd1", bus.ex_opnd1, 32'd77);

    // EX stall for 3 cycles, then flush during stall; ORI r10, r11, 0xF0F0 waiting
    bus.ex_stall = 1'b1; bus.rdata1 = 32'h55;
    issue(itype(6'h0D, 5'd11, 5'd10, 16'hF0F0), 32'h118);
    for (int i = 0; i < 3; i++) begin
      chk("stall_id_stall", bus.id_stall, 1);
      tick();
      chk("stall_hold_valid", bus.ex_valid, 1);
      chk("stall_hold_waddr", bus.ex_waddr, 6);
      chk("stall_hold_opnd1", bus.ex_opnd1, 32'd77);
      chk("stall_hold_pc", bus.ex_pc, 32'h114);
    end
    bus.flush = 1'b1;
    #1;
    tick();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_we", bus.ex_we, 0);
    bus.flush = 1'b0; bus.ex_stall = 1'b0;
    #1;
    tick();
    chk("ori_valid", bus.ex_valid, 1);
    chk("ori_opnd1", bus.ex_opnd1, 32'h55);
    chk("ori_opnd2", bus.ex_opnd2, 32'h0000_F0F0);
    chk("ori_aluop", bus.ex_aluop, 3);
    chk("ori_waddr", bus.ex_waddr, 10);

    // LUI r2, 0x1234
    idle();
    issue(itype(6'h0F, 5'd0, 5'd2, 16'h1234), 32'h11C);
    chk("lui_re1", bus.re1, 0);
    tick();
    chk("lui_opnd1", bus.ex_opnd1, 0);
    chk("lui_opnd2", bus.ex_opnd2, 32'h1234_0000);
    chk("lui_aluop", bus.ex_aluop, 3);
    chk("lui_we", bus.ex_we, 1);

    // SW r7, -4(r8)
    bus.rdata1 = 32'h0000_1000; bus.rdata2 = 32'hCAFE_BABE;
    issue(itype(6'h2B, 5'd8, 5'd7, 16'hFFFC), 32'h120);
    chk("sw_re2", bus.re2, 1);
    chk("sw_raddr2", bus.raddr2, 7);
    tick();
    chk("sw_mem_wr", bus.ex_mem_wr, 1);
    chk("sw_mem_rd", bus.ex_mem_rd, 0);
    chk("sw_we", bus.ex_we, 0);
    chk("sw_store_data", bus.ex_store_data, 32'hCAFE_BABE);
    chk("sw_opnd1", bus.ex_opnd1, 32'h0000_1000);
    chk("sw_opnd2", bus.ex_opnd2, 32'hFFFF_FFFC);

    // LW r9, 8(r8)
    issue(itype(6'h23, 5'd8, 5'd9, 16'd8), 32'h124);
    chk("lw_re2", bus.re2, 0);
    tick();
    chk("lw_mem_rd", bus.ex_mem_rd, 1);
    chk("lw_we", bus.ex_we, 1);
    chk("lw_waddr", bus.ex_waddr, 9);
    chk("lw_opnd2", bus.ex_opnd2, 32'd8);

    // SLL r5, r3, 4
    bus.rdata2 = 32'h11;
    issue(rtype(5'd0, 5'd3, 5'd5, 5'd4, 6'h00), 32'h128);
    chk("sll_re1", bus.re1, 0);
    tick();
    chk("sll_opnd1", bus.ex_opnd1, 32'h11);
    chk("sll_opnd2", bus.ex_opnd2, 32'd4);
    chk("sll_aluop", bus.ex_aluop, 6);

    // SLT r1, r2, r3 and XORI r4, r4, 0x8001
    issue(rtype(5'd2, 5'd3, 5'd1, 5'd0, 6'h2A), 32'h12C);
    tick();
    chk("slt_aluop", bus.ex_aluop, 5);
    bus.rdata1 = 32'hFFFF_0000;
    issue(itype(6'h0E, 5'd4, 5'd4, 16'h8001), 32'h130);
    tick();
    chk("xori_aluop", bus.ex_aluop, 4);
    chk("xori_opnd2", bus.ex_opnd2, 32'h0000_8001);

    // Unknown opcode 6'h3F, then unknown funct
    issue({6'h3F, 26'h0ABCDEF}, 32'h134);
    tick();
    chk("illegal_op_valid", bus.ex_valid, 0);
    chk("illegal_op_we", bus.ex_we, 0);
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'h138);
    tick();
    chk("illegal_fn_valid", bus.ex_valid, 0);

    // Valid instruction then asynchronous reset without a clock edge
    issue(itype(6'h09, 5'd0, 5'd12, 16'd5), 32'h13C);
    tick();
    chk("pre_arst_valid", bus.ex_valid, 1);
    rst = 1'b0;
    #1;
    chk("arst_valid", bus.ex_valid, 0);
    chk("arst_opnd2", bus.ex_opnd2, 0);
    chk("arst_pc", bus.ex_pc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the toy CPU pipeline, sitting between the IF/ID latch and the EX stage and directly upstream of the register file's two read ports. It decodes a 32-bit MIPS-subset instruction and drives `re1/raddr1` and `re2/raddr2` on the register file. It resolves operands with EX/MEM forwarding, detects load-use hazards, and holds the ID/EX pipeline register with stall and flush control.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  **asynchronous, active-low reset**.
- `if_valid`  in  1  IF/ID holds a live instruction.
- `if_inst`  in  32  instruction word.
- `if_pc`  in  32  its PC.
- `id_stall`  out  1  upstream must hold IF/ID this cycle.
- `ex_stall`  in  1  EX cannot accept; ID/EX holds.
- `flush`  in  1  kill the ID/EX contents.
- `re1`, `re2`  out  1 each  regfile read enables.
- `raddr1`, `raddr2`  out  5 each  regfile read addresses.
- `rdata1`, `rdata2`  in  32 each  regfile read data.
  - Combinational; the regfile bypasses same-cycle writeback internally.
- `fw_ex_we`, `fw_ex_load`  in  1 each  EX-stage result is valid / EX-stage instruction is a load.
- `fw_ex_waddr`  in  5  EX-stage destination.
- `fw_ex_wdata`  in  32  EX-stage result.
- `fw_mem_we`  in  1  MEM-stage result is valid.
- `fw_mem_waddr`  in  5  MEM-stage destination.
- `fw_mem_wdata`  in  32  MEM-stage result.
- `ex_valid`  out  1  ID/EX holds a live instruction.
- `ex_aluop`  out  4  ALU operation.
- `ex_opnd1`, `ex_opnd2`  out  32 each  ALU operands.
- `ex_we`  out  1  register write.
- `ex_waddr`  out  5  destination register.
- `ex_mem_rd`, `ex_mem_wr`  out  1 each  load / store.
- `ex_store_data`  out  32  store data (rt value).
- `ex_pc`  out  32  PC of the instruction.

## Operation
Supported subset:
- R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLL, SRL.
- I-type: ADDIU, ANDI, ORI, XORI, LUI, LW, SW.
- Any other encoding decodes as a bubble, with `ex_valid`=0 in the next cycle.

Register reads:
- `raddr1`=rs, `raddr2`=rt.
- `re1` is asserted only when rs is used; SLL and SRL do not use rs.
- `re2` is asserted for R-type and SW only.

Immediates:
- Sign-extended for ADDIU, LW, SW.
- Zero-extended for ANDI, ORI, XORI.

Operand mapping:
- LUI: opnd1=0, opnd2=imm<<16, aluop OR.
- SLL/SRL: opnd1=rt value, opnd2={27'b0, shamt}.
- LW/SW: aluop ADD, opnd2=sign-extended offset.

Forwarding, per source register, in priority order:
1. Address 0 always yields 0.
2. EX result, if `fw_ex_we` and address matches.
3. MEM result, if `fw_mem_we` and address matches.
4. Otherwise the regfile data.

Destination and write enable:
- Destination is rd for R-type, rt for I-type.
- `ex_we` is forced to 0 when the destination is 0, for SW, and for bubbles.

Load-use hazard:
- Condition: `if_valid && fw_ex_load && fw_ex_we && fw_ex_waddr!=0`, and `fw_ex_waddr` equals a source register that is actually read.
- Response: `id_stall`=1 and a bubble is loaded into ID/EX.

Stall and flush:
- `id_stall` = `load_use | ex_stall`.

## Timing
- Decode, forwarding and hazard detection are combinational within the cycle.
- ID/EX outputs update on the rising `clk`: 1-cycle latency from IF/ID to `ex_*`.

ID/EX update rule, highest priority first:
1. `flush`: clear `ex_valid`, `ex_we`, `ex_mem_rd`, `ex_mem_wr`. This overrides `ex_stall`.
2. `ex_stall`: hold every `ex_*` output unchanged.
3. Load-use hazard: load a bubble.
4. `!if_valid`: load a bubble.
5. Otherwise: load the decoded instruction.

Bubble contents: all control bits 0; data fields are don't-care but are driven to 0.

Reset (`rst`=0, asynchronous):
- Every `ex_*` output goes to 0.
- `id_stall`, `re1`, `re2`, `raddr1`, `raddr2` are combinational and follow their inputs; with `if_valid`=0 they drive 0.
- Deassertion takes effect on the next `clk` edge; there is no partial state.

## Structure
- Shared package `cpu_defs` holds:
  - opcode constants: OP_SPECIAL=6'h00, ADDIU=6'h09, ANDI=6'h0C, ORI=6'h0D, XORI=6'h0E, LUI=6'h0F, LW=6'h23, SW=6'h2B;
  - funct codes;
  - ALU ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7.
- One combinational sub-module, `id_decode`: instruction → aluop, immediate selection, read enables, destination, memory flags, illegal flag.
- Forwarding, hazard detection and the ID/EX register live in `id_stage`.

## Test plan
1. **Reset:** hold `rst`=0 with random inputs → all `ex_*`=0 and `id_stall`=0; release, issue ADDIU r1,r0,-1 → next cycle `ex_valid`=1, `ex_opnd1`=0, `ex_opnd2`=0xFFFFFFFF, `ex_aluop`=ADD, `ex_waddr`=1, `ex_we`=1.
2. **Forwarding:** regfile r19=123456; EX writes r19=654321 and MEM writes r19=233; ADDU r3,r19,r19 → both operands 654321. With EX write disabled → both operands 233.
3. **r0 guard:** `fw_ex_we`=1, `fw_ex_waddr`=0, `fw_ex_wdata`=99; OR r4,r0,r0 → operands 0. Also ADDU r0,r1,r1 → `ex_we`=0.
4. **Load-use:** `fw_ex_load`=1, `fw_ex_waddr`=5; ADDU r6,r5,r0 → `id_stall`=1 and next `ex_valid`=0. Clear the load → the following cycle issues with `ex_waddr`=6.
5. **Stall and flush:** `ex_stall` held for 3 cycles → `ex_*` outputs constant and `id_stall`=1 throughout. Assert `flush` together with `ex_stall` → next `ex_valid`=0.
6. **Decode coverage:** LUI r2,0x1234 → `ex_opnd2`=0x12340000, aluop OR. SW r7,-4(r8) → `ex_mem_wr`=1, `ex_we`=0, `ex_store_data`=r7 value. Unknown opcode 6'h3F → `ex_valid`=0.
